// File: rtl/lsu_bridge.sv
// lsu_bridge: turns the single-cycle core's combinational data-memory request
// into a registered valid/ready bus transaction. The core is stalled while
// the transaction is in flight, and load data comes back sign- or zero-extended.
// Misaligned or illegal accesses are refused without a bus cycle.
module lsu_bridge #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // The watchdog fires on the last allowed REQ cycle. A zero TIMEOUT disables it.
  localparam bit          WdEnable = (TIMEOUT > 0);
  localparam logic [31:0] WdLimit  = WdEnable ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      stateReg;
  logic [1:0]  offReg;
  logic [2:0]  f3Reg;
  logic [31:0] wdCnt;
  logic        timeoutReg;

  logic        req;
  logic        bad;
  logic [3:0]  strbNext;
  logic [31:0] wdataNext;
  logic [31:0] loadData;
  logic [7:0]  laneByte [4];
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign req = MemWrite | MemRead;

  // Classify the access: reject reserved sizes, unsigned stores and misalignment
  always_comb begin
    bad = 1'b0;
    case (funct3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = ALUResult[0];
      3'b010:  bad = (ALUResult[1:0] != 2'b00);
      3'b100:  bad = MemWrite;
      3'b101:  bad = MemWrite | ALUResult[0];
      default: bad = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data for the current request
  always_comb begin
    strbNext  = 4'b1111;
    wdataNext = WriteData;
    case (funct3[1:0])
      2'b00: begin
        strbNext  = 4'b0001 << ALUResult[1:0];
        wdataNext = {4{WriteData[7:0]}};
      end
      2'b01: begin
        strbNext  = 4'b0011 << ALUResult[1:0];
        wdataNext = {2{WriteData[15:0]}};
      end
      default: begin
        strbNext  = 4'b1111;
        wdataNext = WriteData;
      end
    endcase
  end

  // Split the returned word into byte lanes
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    assign laneByte[gi] = bus_rdata[8*gi +: 8];
  end

  assign byteSel = laneByte[offReg];
  assign halfSel = offReg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  // Extend the selected lane using the latched access size and sign
  always_comb begin
    case (f3Reg)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = bus_rdata;
    endcase
  end

  assign Stall    = ((stateReg == IDLE) && req && !bad) || (stateReg == REQ);
  assign MemFault = ((stateReg == IDLE) && req && bad) ||
                    ((stateReg == DONE) && timeoutReg);

  // Transaction sequencer: accept in IDLE, hold the bus in REQ, release the core in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_wstrb  <= 4'd0;
      ReadData   <= 32'd0;
      offReg     <= 2'd0;
      f3Reg      <= 3'd0;
      wdCnt      <= 32'd0;
      timeoutReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          timeoutReg <= 1'b0;
          if (req && !bad) begin
            bus_valid <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {ALUResult[31:2], 2'b00};
            bus_wdata <= wdataNext;
            bus_wstrb <= MemWrite ? strbNext : 4'b0000;
            offReg    <= ALUResult[1:0];
            f3Reg     <= funct3;
            wdCnt     <= 32'd0;
            stateReg  <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            if (!bus_we) begin
              ReadData <= loadData;
            end
            bus_valid <= 1'b0;
            stateReg  <= DONE;
          end else if (WdEnable && (wdCnt == WdLimit)) begin
            bus_valid  <= 1'b0;
            ReadData   <= 32'd0;
            timeoutReg <= 1'b1;
            stateReg   <= DONE;
          end else begin
            wdCnt <= wdCnt + 32'd1;
          end
        end
        DONE: begin
          wdCnt      <= 32'd0;
          timeoutReg <= 1'b0;
          stateReg   <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bridge.sv
// Directed bench for lsu_bridge. One instance keeps the watchdog disabled,
// the other uses TIMEOUT=4. Both share the request and bus inputs.
module tb_lsu_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, bus_rdata;
  logic        bus_ready;

  logic [31:0] rdA, addrA, wdataA, rdB, addrB, wdataB;
  logic        stallA, faultA, validA, weA, stallB, faultB, validB, weB;
  logic [3:0]  wstrbA, wstrbB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_bridge dutA (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(rdA), .Stall(stallA), .MemFault(faultA), .bus_valid(validA),
    .bus_ready(bus_ready), .bus_we(weA), .bus_addr(addrA), .bus_wdata(wdataA),
    .bus_wstrb(wstrbA), .bus_rdata(bus_rdata)
  );

  lsu_bridge #(.TIMEOUT(4)) dutB (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(rdB), .Stall(stallB), .MemFault(faultB), .bus_valid(validB),
    .bus_ready(bus_ready), .bus_we(weB), .bus_addr(addrB), .bus_wdata(wdataB),
    .bus_wstrb(wstrbB), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and hold it while Stall is high. Returns in DONE.
  task automatic runAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata, input int delay,
                           output int stalls, output logic [31:0] capAddr,
                           output logic [31:0] capWdata, output logic [3:0] capStrb,
                           output logic capWe);
    int k;
    k        = 0;
    stalls   = 0;
    capAddr  = 'x;
    capWdata = 'x;
    capStrb  = 'x;
    capWe    = 1'bx;
    MemWrite  = we;
    MemRead   = !we;
    funct3    = f3;
    ALUResult = addr;
    WriteData = data;
    bus_rdata = rdata;
    bus_ready = (delay == 0);
    #1;
    while (stallA && stalls < 40) begin
      stalls++;
      @(posedge clk);
      #1;
      if (validA) begin
        if (k == 0) begin
          capAddr  = addrA;
          capWdata = wdataA;
          capStrb  = wstrbA;
          capWe    = weA;
        end
        bus_ready = (k >= delay);
        k++;
      end
      #1;
    end
  endtask

  task automatic endAccess();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int          st;
  int          cnt;
  logic [31:0] ca, cw;
  logic [3:0]  cs;
  logic        cwe;

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; funct3 = 3'd0;
    ALUResult = 32'd0; WriteData = 32'd0; bus_rdata = 32'd0; bus_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", {31'd0, validA}, 32'd0);
    check("rst_we", {31'd0, weA}, 32'd0);
    check("rst_addr", addrA, 32'd0);
    check("rst_wdata", wdataA, 32'd0);
    check("rst_wstrb", {28'd0, wstrbA}, 32'd0);
    check("rst_rdata", rdA, 32'd0);
    check("rst_fault", {31'd0, faultA}, 32'd0);
    check("rst_stall", {31'd0, stallA}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // SW 0x100
    runAccess(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, st, ca, cw, cs, cwe);
    $display("SW  addr=%h stalls=%0d baddr=%h wdata=%h wstrb=%b", 32'h100, st, ca, cw, cs);
    check("sw_stalls", st, 2);
    check("sw_addr", ca, 32'h100);
    check("sw_wstrb", {28'd0, cs}, 32'hF);
    check("sw_wdata", cw, 32'hDEADBEEF);
    check("sw_we", {31'd0, cwe}, 32'd1);
    check("sw_done_valid", {31'd0, validA}, 32'd0);
    check("sw_done_fault", {31'd0, faultA}, 32'd0);
    endAccess();

    // SB 0x203
    runAccess(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, st, ca, cw, cs, cwe);
    $display("SB  addr=%h stalls=%0d baddr=%h wdata=%h wstrb=%b", 32'h203, st, ca, cw, cs);
    check("sb_addr", ca, 32'h200);
    check("sb_wstrb", {28'd0, cs}, 32'h8);
    check("sb_wdata", cw, 32'hA5A5A5A5);
    endAccess();

    // LW 0x104
    runAccess(1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 0, st, ca, cw, cs, cwe);
    $display("LW  addr=%h stalls=%0d rdata=%h", 32'h104, st, rdA);
    check("lw_rdata", rdA, 32'h12345678);
    check("lw_we", {31'd0, cwe}, 32'd0);
    endAccess();

    // LB 0x101, ready delayed by 3 cycles
    runAccess(1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 3, st, ca, cw, cs, cwe);
    $display("LB  addr=%h stalls=%0d rdata=%h", 32'h101, st, rdA);
    check("lb_stalls", st, 5);
    check("lb_addr", ca, 32'h100);
    check("lb_wstrb", {28'd0, cs}, 32'h0);
    check("lb_rdata", rdA, 32'hFFFFFF80);
    endAccess();
    check("lb_rdata_held", rdA, 32'hFFFFFF80);

    // LBU 0x101
    runAccess(1'b0, 3'b100, 32'h101, 32'h0, 32'h00008000, 3, st, ca, cw, cs, cwe);
    $display("LBU addr=%h stalls=%0d rdata=%h", 32'h101, st, rdA);
    check("lbu_stalls", st, 5);
    check("lbu_rdata", rdA, 32'h00000080);
    endAccess();

    // LH 0x102
    runAccess(1'b0, 3'b001, 32'h102, 32'h0, 32'h80000000, 0, st, ca, cw, cs, cwe);
    $display("LH  addr=%h stalls=%0d rdata=%h", 32'h102, st, rdA);
    check("lh_rdata", rdA, 32'hFFFF8000);
    endAccess();

    // SH 0x202: strobes upper half, ReadData untouched
    runAccess(1'b1, 3'b001, 32'h202, 32'h00001234, 32'hCAFEF00D, 0, st, ca, cw, cs, cwe);
    $display("SH  addr=%h stalls=%0d baddr=%h wdata=%h wstrb=%b", 32'h202, st, ca, cw, cs);
    check("sh_wstrb", {28'd0, cs}, 32'hC);
    check("sh_wdata", cw, 32'h12341234);
    check("sh_rdata_kept", rdA, 32'hFFFF8000);
    endAccess();

    // LW 0x102: misaligned, refused
    MemWrite = 1'b0; MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h102;
    #1;
    $display("LW  addr=%h fault=%b stall=%b valid=%b", 32'h102, faultA, stallA, validA);
    check("lwmis_fault", {31'd0, faultA}, 32'd1);
    check("lwmis_stall", {31'd0, stallA}, 32'd0);
    check("lwmis_valid", {31'd0, validA}, 32'd0);
    endAccess();
    check("lwmis_fault_clr", {31'd0, faultA}, 32'd0);
    check("lwmis_valid_after", {31'd0, validA}, 32'd0);
    check("lwmis_rdata", rdA, 32'hFFFF8000);

    // Store with unsigned size code: illegal
    MemWrite = 1'b1; MemRead = 1'b0; funct3 = 3'b100; ALUResult = 32'h200;
    #1;
    $display("SBU addr=%h fault=%b stall=%b", 32'h200, faultA, stallA);
    check("sbu_fault", {31'd0, faultA}, 32'd1);
    check("sbu_stall", {31'd0, stallA}, 32'd0);
    endAccess();

    // Watchdog on dutB: bus_ready held low
    check("wd_pre_rdata", rdB, 32'hFFFF8000);
    MemWrite = 1'b0; MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h300;
    bus_ready = 1'b0;
    #1;
    check("wd_stall_idle", {31'd0, stallB}, 32'd1);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (validB) cnt++;
      else break;
    end
    $display("WD  addr=%h valid_cycles=%0d fault=%b rdata=%h", 32'h300, cnt, faultB, rdB);
    check("wd_valid_cycles", cnt, 4);
    check("wd_fault", {31'd0, faultB}, 32'd1);
    check("wd_rdata", rdB, 32'd0);
    check("wd_stall_done", {31'd0, stallB}, 32'd0);
    endAccess();
    check("wd_idle_fault", {31'd0, faultB}, 32'd0);
    check("wd_idle_valid", {31'd0, validB}, 32'd0);
    check("wd_idle_stall", {31'd0, stallB}, 32'd0);
    check("nowd_still_req", {31'd0, validA}, 32'd1);

    // Asynchronous reset while dutA waits in REQ
    #2 reset = 1'b1;
    #1;
    $display("RST mid-REQ valid=%b stall=%b rdata=%h", validA, stallA, rdA);
    check("rstreq_valid", {31'd0, validA}, 32'd0);
    check("rstreq_rdata", rdA, 32'd0);
    check("rstreq_stall", {31'd0, stallA}, 32'd0);
    check("rstreq_addr", addrA, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rstreq_idle_valid", {31'd0, validA}, 32'd0);
    check("rstreq_idle_stall", {31'd0, stallA}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
